display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed driver for the slot machine's common-anode 7-segment display bank. Runs on the 6 MHz system clock and consumes the 1 kHz scan clock produced by the clock divider as a sampled input, not as a clock. Each rising edge of that scan clock advances to the next digit. The block decodes that digit's 4-bit value to segments and drives the matching digit-select line. Game logic supplies all digit values in parallel; the scanner snapshots them once per frame so a frame never shows mixed old and new values.

## Interface
- DIGITS, default 4: number of multiplexed digits (2..8).
- GAP_CYCLES, default 600: anti-ghost blank length in clock6MHz cycles (100 µs); used only when the gap feature is compiled in.

Ports:
- clock6MHz  input  1  system clock; every flop is clocked on its rising edge.
- resetN  input  1  asynchronous, active-low reset.
- clock1KHz  input  1  scan clock from the divider; treated as asynchronous data and synchronised internally.
- digitValues  input  4*DIGITS  value of digit i on bits [4i+3:4i]; digit 0 is rightmost.
- dpMask  input  DIGITS  bit i lights the decimal point of digit i.
- blankMask  input  DIGITS  bit i blanks digit i completely.
- segment  output  7  {g,f,e,d,c,b,a}, active-high.
- dp  output  1  decimal point, active-high.
- digitSelect  output  DIGITS  active-low; at most one bit is low at any time.

## Operation
- Synchroniser: two flops, sync1 then sync2, followed by a prev flop. tick = sync2 & ~prev.
- State machine: IDLE → (BLANK) → DRIVE.
  - IDLE is entered on reset; outputs are dark. The first tick moves to DRIVE for digit 0, or to BLANK if the gap feature is enabled.
  - On each tick from DRIVE or BLANK: digitIndex increments, wrapping from DIGITS-1 to 0. Next state is BLANK if the gap is enabled, otherwise DRIVE.
- Frame snapshot: when digitIndex wraps to 0, and on the IDLE exit, digitValues, dpMask and blankMask are latched into shadow registers. Every digit in the frame is driven from the shadow copies.
- Decode, value → segment:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F
  - A:77, b:7C, C:39, d:5E, E:79, F:71
- Blanked digit: segment=0, dp=0, digitSelect all ones for the whole slot. The index still advances normally.
- segment, dp and digitSelect are registered; none is driven combinationally from an input.

## Timing
- Reset values: segment=7'h00, dp=0, digitSelect all ones, digitIndex=0, state IDLE, shadow registers 0, sync/prev 0.
- Latency: clock1KHz rises before edge k. Then sync1=1 at k, sync2=1 at k+1, tick is high between k+1 and k+2. Outputs for the new digit appear at edge k+2.
- tick lasts exactly one cycle per scan-clock rising edge. Scan-clock falling edges have no effect.
- Back-to-back ticks (scan clock faster than the gap): BLANK restarts its counter at each tick; DRIVE is never reached until a full GAP_CYCLES passes. This is legal and produces no error.
- digitValues changing mid-frame: no effect until the next wrap to digit 0.
- resetN asserted mid-scan: all outputs go to reset values immediately, asynchronously. After release the block waits in IDLE for the next tick, and the first digit driven is digit 0.
- digitSelect transitions glitch-free: it moves from one-hot-low to all-ones or to the next one-hot-low in a single edge.

## Configuration
- DISPLAY_GHOST_BLANK_EN defined:
  - Each slot starts in BLANK. segment and dp update at k+2 while digitSelect is held all ones for GAP_CYCLES cycles.
  - The state then moves to DRIVE and the digit's select goes low.
- DISPLAY_GHOST_BLANK_EN undefined:
  - There is no BLANK state and no gap counter; GAP_CYCLES is ignored.
  - digitSelect goes low on the same edge (k+2) as segment updates.

## Test plan
- Reset then idle: hold resetN=0, toggle clock1KHz → segment=00, dp=0, digitSelect=4'b1111 throughout; after release, no output change before the first scan-clock rise.
- Basic scan, gap disabled: digitValues=16'h4321, masks 0 → successive ticks give (digitSelect, segment) = (1110,06), (1101,5B), (1011,4F), (0111,66), then wraps to (1110,06); each change lands exactly 2 edges after sync1 captures the rise.
- Frame snapshot: change digitValues to 16'h8888 while digit 1 is driven → digits 2 and 3 still show 3 and 4; 7F appears only from the next digit 0.
- Masks: blankMask=4'b0100, dpMask=4'b0001, values 16'h0F0A → digit0 segment=77 dp=1; digit1 segment=3F; digit2 digitSelect=1111 segment=00; digit3 segment=3F.
- Ghost gap (macro defined, GAP_CYCLES=600): each slot shows digitSelect=1111 for exactly 600 cycles after the segment update, then a single low bit. A second tick 300 cycles in keeps select high and restarts the count.
- Async reset mid-frame: pull resetN low while digit 2 is driven → outputs reach reset values with no clock edge; after release, the first driven digit is digit 0.

Source files
------------

// File: rtl/display_scanner.sv
// Multiplexed 7-seg scanner: one digit per clock1KHz rise, outputs registered 2 cycles after sync1 sees it; no backpressure.
// Define DISPLAY_GHOST_BLANK_EN to hold digitSelect dark for GAP_CYCLES at the start of each slot.
module display_scanner #(
    parameter int DIGITS     = 4,
    parameter int GAP_CYCLES = 600
) (
    input  logic                  clock6MHz,
    input  logic                  resetN,
    input  logic                  clock1KHz,
    input  logic [4*DIGITS-1:0]   digitValues,
    input  logic [DIGITS-1:0]     dpMask,
    input  logic [DIGITS-1:0]     blankMask,
    output logic [6:0]            segment,
    output logic                  dp,
    output logic [DIGITS-1:0]     digitSelect
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE      = DIGITS'(1);

    if (DIGITS < 2 || DIGITS > 8 || GAP_CYCLES < 1) begin : g_param_check
        $error("display_scanner: DIGITS must be 2..8 and GAP_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t                state_q;
    logic                  sync1_q, sync2_q, prev_q;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   sh_vals_q, sh_vals_d;
    logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]     sh_blank_q, sh_blank_d;
    logic                  tick;
    logic                  snap;
    logic [3:0]            nib_d;
    logic [6:0]            seg_dec;
    logic [DIGITS-1:0]     sel_next;
    logic [DIGITS-1:0]     sel_cur;

    assign tick = sync2_q & ~prev_q;

    always_ff @(posedge clock6MHz or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= clock1KHz;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Next slot is decoded from the shadow copy it will see, so a wrap uses the fresh snapshot.
    always_comb begin
        idx_d      = (state_q == IDLE || idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        snap       = (idx_d == '0);
        sh_vals_d  = snap ? digitValues : sh_vals_q;
        sh_dp_d    = snap ? dpMask      : sh_dp_q;
        sh_blank_d = snap ? blankMask   : sh_blank_q;
        nib_d      = sh_vals_d[4*int'(idx_d) +: 4];
        sel_next   = ~(ONE << idx_d);
        sel_cur    = ~(ONE << idx_q);
    end

    always_comb begin
        seg_dec = 7'h00;
        case (nib_d)
            4'h0: seg_dec = 7'h3F;
            4'h1: seg_dec = 7'h06;
            4'h2: seg_dec = 7'h5B;
            4'h3: seg_dec = 7'h4F;
            4'h4: seg_dec = 7'h66;
            4'h5: seg_dec = 7'h6D;
            4'h6: seg_dec = 7'h7D;
            4'h7: seg_dec = 7'h07;
            4'h8: seg_dec = 7'h7F;
            4'h9: seg_dec = 7'h6F;
            4'hA: seg_dec = 7'h77;
            4'hB: seg_dec = 7'h7C;
            4'hC: seg_dec = 7'h39;
            4'hD: seg_dec = 7'h5E;
            4'hE: seg_dec = 7'h79;
            4'hF: seg_dec = 7'h71;
            default: seg_dec = 7'h00;
        endcase
    end

`ifdef DISPLAY_GHOST_BLANK_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0] gap_cnt_q;
`endif

    always_ff @(posedge clock6MHz or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sh_vals_q   <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            segment     <= 7'h00;
            dp          <= 1'b0;
            digitSelect <= '1;
`ifdef DISPLAY_GHOST_BLANK_EN
            gap_cnt_q   <= '0;
`endif
        end else if (tick) begin
            idx_q      <= idx_d;
            sh_vals_q  <= sh_vals_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            segment    <= sh_blank_d[idx_d] ? 7'h00 : seg_dec;
            dp         <= sh_blank_d[idx_d] ? 1'b0  : sh_dp_d[idx_d];
`ifdef DISPLAY_GHOST_BLANK_EN
            // A tick during the gap simply restarts it.
            state_q     <= BLANK;
            gap_cnt_q   <= '0;
            digitSelect <= '1;
`else
            state_q     <= DRIVE;
            digitSelect <= sh_blank_d[idx_d] ? '1 : sel_next;
`endif
        end
`ifdef DISPLAY_GHOST_BLANK_EN
        else if (state_q == BLANK) begin
            if (gap_cnt_q == GAP_LAST) begin
                state_q     <= DRIVE;
                digitSelect <= sh_blank_q[idx_q] ? '1 : sel_cur;
            end else begin
                gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
        end
`endif
    end

`ifndef DISPLAY_GHOST_BLANK_EN
    logic unused_sel_cur;
    assign unused_sel_cur = ^sel_cur;
`endif

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner (DIGITS=4): reset, vector table, ghost-gap corners, random scan, async reset.
module tb_display_scanner;
`ifdef DISPLAY_GHOST_BLANK_EN
    localparam int GAP = 600;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk1k = 1'b0;
    logic [15:0] digitValues = '0;
    logic [3:0]  dpMask = '0;
    logic [3:0]  blankMask = '0;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  digitSelect;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] last_sel = 4'hF;
    logic [6:0] last_seg = 7'h00;

    // Reference model state: which digit the next tick shows, plus the frame snapshot.
    bit         m_run = 0;
    int         m_idx = 0;
    logic [15:0] m_v  = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_bm = '0;
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dm;
        logic [3:0]  bm;
        logic [3:0]  esel;
        logic [6:0]  eseg;
        logic        edp;
    } vec_t;
    vec_t vecs [13];

    display_scanner #(.DIGITS(4), .GAP_CYCLES(600)) dut (
        .clock6MHz   (clk),
        .resetN      (rst_n),
        .clock1KHz   (clk1k),
        .digitValues (digitValues),
        .dpMask      (dpMask),
        .blankMask   (blankMask),
        .segment     (segment),
        .dp          (dp),
        .digitSelect (digitSelect)
    );

    always #83 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_tick(input logic [15:0] v, input logic [3:0] dm, input logic [3:0] bm,
                              output logic [3:0] esel, output logic [6:0] eseg, output logic edp);
        int d;
        if (!m_run) begin
            m_run = 1;
            m_idx = 0;
        end else begin
            m_idx = (m_idx + 1) % 4;
        end
        if (m_idx == 0) begin
            m_v = v; m_dp = dm; m_bm = bm;
        end
        d = (m_v >> (4 * m_idx)) & 15;
        if (m_bm[m_idx]) begin
            esel = 4'hF; eseg = 7'h00; edp = 1'b0;
        end else begin
            esel = ~(4'b0001 << m_idx); eseg = seg_tab[d]; edp = m_dp[m_idx];
        end
    endtask

    // Raises the scan clock before edge k and returns just after edge k+2.
    task automatic pulse_to_k2();
        @(negedge clk); clk1k = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("hold_sel_k1", digitSelect, last_sel);
        check("hold_seg_k1", segment, last_seg);
        @(posedge clk); #1;
        clk1k = 1'b0;
    endtask

    task automatic tick_check(input logic [15:0] v, input logic [3:0] dm, input logic [3:0] bm,
                              input logic [3:0] esel, input logic [6:0] eseg, input logic edp);
        digitValues = v; dpMask = dm; blankMask = bm;
        pulse_to_k2();
        check("seg_k2", segment, eseg);
        check("dp_k2", dp, edp);
`ifdef DISPLAY_GHOST_BLANK_EN
        check("sel_gap_start", digitSelect, 4'hF);
        repeat (GAP - 1) @(posedge clk);
        #1 check("sel_gap_end", digitSelect, 4'hF);
        @(posedge clk); #1;
`endif
        check("sel", digitSelect, esel);
        repeat (4) @(posedge clk);
        #1;
        check("sel_after_fall", digitSelect, esel);
        check("seg_after_fall", segment, eseg);
        last_sel = esel;
        last_seg = eseg;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; clk1k = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_run = 0; last_sel = 4'hF; last_seg = 7'h00;
    endtask

    initial begin
        logic [3:0] es; logic [6:0] eg; logic ed;
        logic [15:0] rv; logic [3:0] rd, rb;

        vecs[0]  = '{16'h4321, 4'h0, 4'h0, 4'b1110, 7'h06, 1'b0};
        vecs[1]  = '{16'h4321, 4'h0, 4'h0, 4'b1101, 7'h5B, 1'b0};
        vecs[2]  = '{16'h4321, 4'h0, 4'h0, 4'b1011, 7'h4F, 1'b0};
        vecs[3]  = '{16'h4321, 4'h0, 4'h0, 4'b0111, 7'h66, 1'b0};
        vecs[4]  = '{16'h0F0A, 4'h1, 4'h4, 4'b1110, 7'h77, 1'b1};
        vecs[5]  = '{16'h0F0A, 4'h1, 4'h4, 4'b1101, 7'h3F, 1'b0};
        vecs[6]  = '{16'h0F0A, 4'h1, 4'h4, 4'b1111, 7'h00, 1'b0};
        vecs[7]  = '{16'h0F0A, 4'h1, 4'h4, 4'b0111, 7'h3F, 1'b0};
        vecs[8]  = '{16'h1234, 4'h0, 4'h0, 4'b1110, 7'h66, 1'b0};
        vecs[9]  = '{16'h8888, 4'h0, 4'h0, 4'b1101, 7'h4F, 1'b0};
        vecs[10] = '{16'h8888, 4'h0, 4'h0, 4'b1011, 7'h5B, 1'b0};
        vecs[11] = '{16'h8888, 4'h0, 4'h0, 4'b0111, 7'h06, 1'b0};
        vecs[12] = '{16'h8888, 4'h0, 4'h0, 4'b1110, 7'h7F, 1'b0};

        // Reset held while the scan clock toggles: outputs stay dark.
        digitValues = 16'h4321;
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(posedge clk);
            clk1k = ~clk1k;
            #1;
            check("rst_seg", segment, 7'h00);
            check("rst_dp", dp, 1'b0);
            check("rst_sel", digitSelect, 4'hF);
        end
        @(negedge clk); clk1k = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_seg", segment, 7'h00);
        check("idle_sel", digitSelect, 4'hF);

        for (int i = 0; i < 13; i++) begin
            model_tick(vecs[i].v, vecs[i].dm, vecs[i].bm, es, eg, ed);
            tick_check(vecs[i].v, vecs[i].dm, vecs[i].bm, vecs[i].esel, vecs[i].eseg, vecs[i].edp);
        end

`ifdef DISPLAY_GHOST_BLANK_EN
        // Second tick 300 cycles into the gap restarts the count.
        digitValues = 16'h5678; dpMask = 4'h0; blankMask = 4'h0;
        model_tick(digitValues, dpMask, blankMask, es, eg, ed);
        pulse_to_k2();
        check("b2b_seg1", segment, eg);
        check("b2b_sel1", digitSelect, 4'hF);
        repeat (296) @(posedge clk);
        #1 check("b2b_sel_mid", digitSelect, 4'hF);
        last_sel = 4'hF; last_seg = eg;
        model_tick(digitValues, dpMask, blankMask, es, eg, ed);
        pulse_to_k2();
        check("b2b_seg2", segment, eg);
        check("b2b_sel2", digitSelect, 4'hF);
        repeat (GAP - 1) @(posedge clk);
        #1 check("b2b_sel_end", digitSelect, 4'hF);
        @(posedge clk); #1;
        check("b2b_sel_drive", digitSelect, es);
        last_sel = es; last_seg = eg;
`endif

        for (int i = 0; i < 30; i++) begin
            rv = 16'($urandom);
            rd = 4'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            model_tick(rv, rd, rb, es, eg, ed);
            tick_check(rv, rd, rb, es, eg, ed);
        end

        // Async reset while digit 2 is driven, then restart from digit 0.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            model_tick(16'h9ABC, 4'h0, 4'h0, es, eg, ed);
            tick_check(16'h9ABC, 4'h0, 4'h0, es, eg, ed);
        end
        check("pre_rst_sel", digitSelect, 4'b1011);
        @(negedge clk);
        #20 rst_n = 1'b0;
        #1;
        check("arst_seg", segment, 7'h00);
        check("arst_dp", dp, 1'b0);
        check("arst_sel", digitSelect, 4'hF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_run = 0; last_sel = 4'hF; last_seg = 7'h00;
        model_tick(16'h9ABC, 4'h0, 4'h0, es, eg, ed);
        tick_check(16'h9ABC, 4'h0, 4'h0, 4'b1110, 7'h39, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
